decode_stage: RTL

Buffered instruction-decode stage for the RV32 5-stage core. It accepts fetched instruction/PC pairs over a valid/ready handshake and decodes them into a full control bundle. The decoder adds immediate generation, register indices, complete CSR op classes, EBREAK/WFI, and strict funct7 illegal checks. Decoded entries are held in a parametrised FIFO between IF and EX, so fetch and execute stall independently, and the whole stage flushes in one cycle on redirect/trap.

---
 rtl/rv32_pkg.sv | 111 +++++++++++
 rtl/rv32_decoder.sv | 165 ++++++++++++++++
 rtl/decode_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: ALU/CSR/immediate enums, opcode constants and the
// packed control bundle carried from decode to execute.
package rv32_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

    // Encoding matches funct3[1:0] of the CSR instructions.
    typedef enum logic [1:0] {
        CSR_NONE,
        CSR_RW,
        CSR_RS,
        CSR_RC
    } csr_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_Z
    } imm_sel_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       is_branch;
        logic [2:0] br_cond;
        logic       is_jump;
        logic       is_jalr;
        csr_op_e    csr_op;
        logic       csr_write;
        logic       is_ecall;
        logic       is_ebreak;
        logic       is_mret;
        logic       is_wfi;
        logic       is_illegal;
    } ctrl_t;

    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z:   imm = {27'b0, instr[19:15]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I (+Zicsr) decoder: instruction -> control bundle, immediate, indices.
// Define RV32M_EN to decode the M-extension multiply/divide ops.
module rv32_decoder
    import rv32_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_f;
    logic [4:0] rd_f;

    ctrl_t    ctrl;
    logic     bad;
    imm_sel_e imm_sel;
    logic     imm_en;
    logic     use_rs1;
    logic     use_rs2;
    logic     use_rd;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1_f  = instr_i[19:15];
    assign rd_f   = instr_i[11:7];

    always_comb begin
        ctrl    = '0;
        bad     = 1'b0;
        imm_sel = IMM_I;
        imm_en  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    imm_sel = IMM_U; imm_en = 1'b1; use_rd = 1'b1;
                    ctrl.alu_op = ALU_PASS_B; ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1;
                end
                OPC_AUIPC: begin
                    imm_sel = IMM_U; imm_en = 1'b1; use_rd = 1'b1;
                    ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1;
                end
                OPC_JAL: begin
                    imm_sel = IMM_J; imm_en = 1'b1; use_rd = 1'b1;
                    ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1;
                    ctrl.is_jump = 1'b1;
                end
                OPC_JALR: begin
                    imm_en = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                    ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1;
                    ctrl.is_jump = 1'b1; ctrl.is_jalr = 1'b1;
                    bad = (funct3 != 3'b000);
                end
                OPC_BRANCH: begin
                    imm_sel = IMM_B; imm_en = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    ctrl.alu_op = ALU_SUB; ctrl.is_branch = 1'b1; ctrl.br_cond = funct3;
                    bad = (funct3 == 3'b010) || (funct3 == 3'b011);
                end
                OPC_LOAD: begin
                    imm_en = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                    ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1;
                    ctrl.mem_size = funct3[1:0]; ctrl.mem_unsigned = funct3[2];
                    bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                end
                OPC_STORE: begin
                    imm_sel = IMM_S; imm_en = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    ctrl.alu_src_b = 1'b1; ctrl.mem_write = 1'b1; ctrl.mem_size = funct3[1:0];
                    bad = (funct3 >= 3'b011);
                end
                OPC_OP_IMM: begin
                    imm_en = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                    ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1;
                    ctrl.alu_op = base_alu_op(funct3);
                    if (funct3 == 3'b001) begin
                        bad = (funct7 != F7_BASE);
                    end else if (funct3 == 3'b101) begin
                        if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                        else if (funct7 != F7_BASE) bad = 1'b1;
                    end
                end
                OPC_OP: begin
                    use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                    ctrl.reg_write = 1'b1;
                    case (funct7)
                        F7_BASE: ctrl.alu_op = base_alu_op(funct3);
                        F7_ALT: begin
                            if (funct3 == 3'b000) ctrl.alu_op = ALU_SUB;
                            else if (funct3 == 3'b101) ctrl.alu_op = ALU_SRA;
                            else bad = 1'b1;
                        end
`ifdef RV32M_EN
                        F7_MULDIV: begin
                            case (funct3)
                                3'b000:  ctrl.alu_op = ALU_MUL;
                                3'b001:  ctrl.alu_op = ALU_MULH;
                                3'b010:  ctrl.alu_op = ALU_MULHSU;
                                3'b011:  ctrl.alu_op = ALU_MULHU;
                                3'b100:  ctrl.alu_op = ALU_DIV;
                                3'b101:  ctrl.alu_op = ALU_DIVU;
                                3'b110:  ctrl.alu_op = ALU_REM;
                                default: ctrl.alu_op = ALU_REMU;
                            endcase
                        end
`endif
                        default: bad = 1'b1;
                    endcase
                end
                // FENCE is accepted as a NOP; ordering is trivially preserved in-order.
                OPC_MISC_MEM: imm_en = 1'b1;
                OPC_SYSTEM: begin
                    imm_en = 1'b1;
                    if (funct3 == 3'b000) begin
                        if (rs1_f != 5'd0 || rd_f != 5'd0) begin
                            bad = 1'b1;
                        end else begin
                            case (instr_i[31:20])
                                12'h000: ctrl.is_ecall  = 1'b1;
                                12'h001: ctrl.is_ebreak = 1'b1;
                                12'h302: ctrl.is_mret   = 1'b1;
                                12'h105: ctrl.is_wfi    = 1'b1;
                                default: bad = 1'b1;
                            endcase
                        end
                    end else if (funct3 == 3'b100) begin
                        bad = 1'b1;
                    end else begin
                        use_rd = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.csr_op    = csr_op_e'(funct3[1:0]);
                        ctrl.csr_write = (funct3[1:0] == 2'b01) || (rs1_f != 5'd0);
                        if (funct3[2]) imm_sel = IMM_Z;
                        else use_rs1 = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase
        end
    end

    // Illegal entries carry only the trap flag so no side effect can leak to EX.
    always_comb begin
        ctrl_o = ctrl;
        if (bad) begin
            ctrl_o            = '0;
            ctrl_o.is_illegal = 1'b1;
        end
    end

    assign imm_o = imm_en  ? gen_imm(instr_i, imm_sel) : '0;
    assign rs1_o = use_rs1 ? rs1_f          : '0;
    assign rs2_o = use_rs2 ? instr_i[24:20] : '0;
    assign rd_o  = use_rd  ? rd_f           : '0;

endmodule

// File: rtl/decode_stage.sv
// Buffered RV32 decode stage: decoder feeding a DEPTH-entry FIFO with valid/ready on
// both sides and single-cycle flush. RV32M_EN selects M-extension decode.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output ctrl_t                    out_ctrl,
    output logic [XLEN-1:0]          out_imm,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (XLEN != 32) begin : g_bad_xlen
        $error("decode_stage: XLEN=%0d unsupported, only 32", XLEN);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decode_stage: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end

    typedef struct packed {
        logic [XLEN-1:0] pc;
        ctrl_t           ctrl;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } entry_t;

    ctrl_t       dec_ctrl;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    entry_t      dec_entry;
    entry_t      head;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full, empty, push, pop;

    rv32_decoder u_decoder (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm),
        .rs1_o   (dec_rs1),
        .rs2_o   (dec_rs2),
        .rd_o    (dec_rd)
    );

    assign dec_entry = '{pc: in_pc, ctrl: dec_ctrl, imm: XLEN'(dec_imm),
                         rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd};

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;
    assign pop      = !empty && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; empty gating below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_entry;
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = !empty;
    assign count     = count_q;

    always_comb begin
        out_pc   = '0;
        out_ctrl = '0;
        out_imm  = '0;
        out_rs1  = '0;
        out_rs2  = '0;
        out_rd   = '0;
        if (!empty) begin
            out_pc   = head.pc;
            out_ctrl = head.ctrl;
            out_imm  = head.imm;
            out_rs1  = head.rs1;
            out_rs2  = head.rs2;
            out_rd   = head.rd;
        end
    end

endmodule
